// File: rtl/assoc_cache.sv
// assoc_cache: N-way set-associative, write-through, no-write-allocate cache
// with one data word per line. It sits between a load/store stage and the
// backing data memory. Both sides use a request/response handshake.
//
// Optional feature macro: CACHE_PERF_CNT_EN adds the saturating read hit/miss
// counters hit_cnt_o and miss_cnt_o.
//
// Ports
//   clk_i, rst_i       clock; synchronous active-high reset
//   flush_i            invalidates every line (honoured only in IDLE)
//   req_*              CPU request: valid/ready/we/addr/wdata
//   resp_*             completion pulse, hit flag, read data
//   mem_req_*/mem_*    memory request: valid/ready/we/addr/wdata
//   mem_resp_valid_i   one-cycle read-data strobe with mem_rdata_i
//   hit_cnt_o/miss_cnt_o  read lookup counters (CACHE_PERF_CNT_EN only)
//   dbg_state_o        current FSM state, for observation only
//
// Handshake rule, both sides: a transfer happens on a rising edge where
// valid and ready are both high. The side that asserts valid keeps valid and
// its payload unchanged until that transfer.
module assoc_cache #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int INDEX_W = 8,
    parameter int WAYS    = 2   // 2 or 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              resp_valid_o,
    output logic              resp_hit_o,
    output logic [DATA_W-1:0] resp_rdata_o,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_resp_valid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
`ifdef CACHE_PERF_CNT_EN
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o,
`endif
    output logic [2:0]        dbg_state_o
);

    localparam int TAG_W  = ADDR_W - INDEX_W;
    localparam int SETS   = 1 << INDEX_W;
    localparam int PLRU_W = WAYS - 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOOKUP   = 3'd1,
        MEM_RD   = 3'd2,
        MEM_WAIT = 3'd3,
        MEM_WR   = 3'd4,
        RESP     = 3'd5
    } state_e;

    state_e state_q, state_d;

    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              hit_q;
    logic [DATA_W-1:0] rdata_q;

    logic [WAYS-1:0]   valid_q [SETS];
    logic [PLRU_W-1:0] plru_q  [SETS];
    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    logic [DATA_W-1:0] data_q  [SETS][WAYS];

`ifdef CACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;
    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag_in;
    logic [WAYS-1:0]    valid_cur;
    logic [PLRU_W-1:0]  plru_cur;
    logic [WAYS-1:0]    hit_vec;
    logic               hit;
    logic [DATA_W-1:0]  hit_data;
    logic [WAYS-1:0]    invalid_vec;
    logic [WAYS-1:0]    plru_vict_oh;
    logic [WAYS-1:0]    fill_oh;
    logic [PLRU_W-1:0]  plru_touch_hit;
    logic [PLRU_W-1:0]  plru_touch_fill;

    assign idx       = addr_q[INDEX_W-1:0];
    assign tag_in    = addr_q[ADDR_W-1:INDEX_W];
    assign valid_cur = valid_q[idx];
    assign plru_cur  = plru_q[idx];

    // Tag compare across all ways of the latched index.
    always_comb begin
        hit_vec  = '0;
        hit_data = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_vec[w] = valid_cur[w] && (tag_q[idx][w] == tag_in);
            if (hit_vec[w]) hit_data = data_q[idx][w];
        end
    end
    assign hit = |hit_vec;

    // Refill target: lowest-index invalid way (isolate lowest set bit),
    // otherwise the way the PLRU tree points at.
    assign invalid_vec = ~valid_cur;
    assign fill_oh     = (|invalid_vec) ? (invalid_vec & (-invalid_vec)) : plru_vict_oh;

    // Tree PLRU. Node 0 is the root; for 4 ways node 1 covers ways 0/1 and
    // node 2 covers ways 2/3. A node value of 1 means the victim is in the
    // upper half; touching a way points every node on its path away from it.
    generate
        if (WAYS == 2) begin : g_plru2
            assign plru_vict_oh    = plru_cur[0] ? 2'b10 : 2'b01;
            assign plru_touch_hit  = hit_vec[0];
            assign plru_touch_fill = fill_oh[0];
        end else begin : g_plru4
            assign plru_vict_oh = !plru_cur[0] ? (plru_cur[1] ? 4'b0010 : 4'b0001)
                                               : (plru_cur[2] ? 4'b1000 : 4'b0100);
            assign plru_touch_hit[0]  = ~(hit_vec[2] | hit_vec[3]);
            assign plru_touch_hit[1]  = hit_vec[0] ? 1'b1 : (hit_vec[1] ? 1'b0 : plru_cur[1]);
            assign plru_touch_hit[2]  = hit_vec[2] ? 1'b1 : (hit_vec[3] ? 1'b0 : plru_cur[2]);
            assign plru_touch_fill[0] = ~(fill_oh[2] | fill_oh[3]);
            assign plru_touch_fill[1] = fill_oh[0] ? 1'b1 : (fill_oh[1] ? 1'b0 : plru_cur[1]);
            assign plru_touch_fill[2] = fill_oh[2] ? 1'b1 : (fill_oh[3] ? 1'b0 : plru_cur[2]);
        end
    endgenerate

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (!flush_i && req_valid_i) state_d = LOOKUP;
            LOOKUP:   state_d = we_q ? MEM_WR : (hit ? RESP : MEM_RD);
            MEM_RD:   if (mem_req_ready_i) state_d = MEM_WAIT;
            MEM_WAIT: if (mem_resp_valid_i) state_d = RESP;
            MEM_WR:   if (mem_req_ready_i) state_d = RESP;
            RESP:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Control state, valid bits, PLRU bits and counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            hit_q   <= 1'b0;
            rdata_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
`ifdef CACHE_PERF_CNT_EN
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (flush_i) begin
                        for (int s = 0; s < SETS; s++) begin
                            valid_q[s] <= '0;
                            plru_q[s]  <= '0;
                        end
`ifdef CACHE_PERF_CNT_EN
                        hit_cnt_q  <= '0;
                        miss_cnt_q <= '0;
`endif
                    end else if (req_valid_i) begin
                        we_q    <= req_we_i;
                        addr_q  <= req_addr_i;
                        wdata_q <= req_wdata_i;
                    end
                end
                LOOKUP: begin
                    hit_q <= hit;
                    if (hit) plru_q[idx] <= plru_touch_hit;
                    if (!we_q && hit) rdata_q <= hit_data;
`ifdef CACHE_PERF_CNT_EN
                    if (!we_q) begin
                        if (hit && hit_cnt_q != 32'hFFFF_FFFF)
                            hit_cnt_q <= hit_cnt_q + 32'd1;
                        if (!hit && miss_cnt_q != 32'hFFFF_FFFF)
                            miss_cnt_q <= miss_cnt_q + 32'd1;
                    end
`endif
                end
                MEM_WAIT: begin
                    if (mem_resp_valid_i) begin
                        valid_q[idx] <= valid_cur | fill_oh;
                        plru_q[idx]  <= plru_touch_fill;
                        rdata_q      <= mem_rdata_i;
                        hit_q        <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag/data storage: write hits update in place, refills replace the line.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (state_q == LOOKUP && we_q) begin
                for (int w = 0; w < WAYS; w++)
                    if (hit_vec[w]) data_q[idx][w] <= wdata_q;
            end
            if (state_q == MEM_WAIT && mem_resp_valid_i) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (fill_oh[w]) begin
                        tag_q[idx][w]  <= tag_in;
                        data_q[idx][w] <= mem_rdata_i;
                    end
                end
            end
        end
    end

    // req_ready is held low while rst_i is high so it first rises the cycle
    // after reset is released.
    assign req_ready_o     = (state_q == IDLE) && !flush_i && !rst_i;
    assign resp_valid_o    = (state_q == RESP);
    assign resp_hit_o      = hit_q;
    assign resp_rdata_o    = rdata_q;
    assign mem_req_valid_o = (state_q == MEM_RD) || (state_q == MEM_WR);
    assign mem_we_o        = (state_q == MEM_WR);
    assign mem_addr_o      = addr_q;
    assign mem_wdata_o     = wdata_q;
    assign dbg_state_o     = state_q;

endmodule

// File: doc/assoc_cache.md
# assoc_cache

Parametrised N-way set-associative, write-through, no-write-allocate cache with one word per line and a request/response handshake on both sides. It sits between the MIPS core's load/store stage and the backing data memory. It generalises the earlier fixed 2-way, 256-set, 16-bit cache:
- configurable width, sets and ways
- reset-cleared valid bits
- miss refill from memory
- write-through to memory
- tree pseudo-LRU replacement
- whole-cache flush

## Interface
Parameters:
- ADDR_W, 16, word address width
- DATA_W, 16, data word width
- INDEX_W, 8, set index bits; sets = 2^INDEX_W; TAG_W = ADDR_W - INDEX_W
- WAYS, 2, associativity; legal values 2 or 4

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- flush  in  1  invalidate all lines
- req_valid  in  1  CPU request present
- req_ready  out  1  cache accepts request this cycle
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address; tag = [ADDR_W-1:INDEX_W], index = [INDEX_W-1:0]
- req_wdata  in  DATA_W  write data
- resp_valid  out  1  one-cycle pulse, request complete
- resp_hit  out  1  lookup hit; qualified by resp_valid
- resp_rdata  out  DATA_W  read data; qualified by resp_valid && !req_we of the completed request
- mem_req_valid  out  1  memory request
- mem_req_ready  in  1  memory accepts request
- mem_we  out  1  memory write
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_resp_valid  in  1  read data valid, one cycle
- mem_rdata  in  DATA_W  read data

## Operation
- FSM states: IDLE, LOOKUP, MEM_RD, MEM_WAIT, MEM_WR, RESP.
- IDLE:
  - req_ready = 1 unless flush is high.
  - flush has priority over req_valid: all valid bits and PLRU bits are cleared in one cycle, and no request is accepted that cycle.
  - flush outside IDLE is ignored.
- Accept (req_valid && req_ready): latch we/addr/wdata, go to LOOKUP.
- LOOKUP: compare tag against all ways at the index. Hit requires tag equal AND valid. At most one way can hit (invariant).
  - Read hit: latch data, touch PLRU, go to RESP with hit = 1.
  - Read miss: go to MEM_RD.
  - Write hit: update that way's data, touch PLRU, go to MEM_WR.
  - Write miss: no allocation, no PLRU change, go to MEM_WR.
- MEM_RD:
  - Drives mem_req_valid = 1, mem_we = 0, mem_addr = latched addr.
  - Outputs stay stable until mem_req_ready, then go to MEM_WAIT.
- MEM_WAIT:
  - Waits for mem_resp_valid.
  - Victim way = lowest-index invalid way, else the PLRU victim.
  - Write tag and data, set valid, touch PLRU.
  - Latch mem_rdata and go to RESP with hit = 0.
- MEM_WR:
  - Drives mem_req_valid = 1, mem_we = 1, mem_addr/mem_wdata = latched values.
  - Outputs stay stable until mem_req_ready, then go to RESP. Writes get no memory response.
- RESP: resp_valid = 1 for one cycle, go to IDLE.
- PLRU: WAYS-1 bits per set, arranged as a binary tree.
  - Node bit 0: victim is in the lower half. Node bit 1: victim is in the upper half.
  - Touching way w sets each node on w's path to point away from w.
  - WAYS = 2: one bit; touching way 0 sets it to 1.
- Reset: state IDLE; all valid and PLRU bits 0; all outputs 0 except req_ready, which is 1 from the first cycle after rst deasserts.
- Reset mid-operation (any state): abandon the request; mem_req_valid = 0 the following cycle; no resp_valid is issued for it.

## Timing
- Read hit: accept at cycle N, resp_valid at N+2.
- Read miss: resp_valid 1 cycle after the mem_resp_valid cycle.
- Write (hit or miss): resp_valid 1 cycle after the mem_req_ready cycle.
- Earliest next accept: the cycle after resp_valid.
- req_ready is 0 in every non-IDLE state; no overlapping requests.
- mem_req_valid never drops without mem_req_ready.
- mem_resp_valid outside MEM_WAIT is ignored.

## Configuration
- CACHE_PERF_CNT_EN defined:
  - Adds outputs hit_cnt and miss_cnt, each 32 bits.
  - The counter matching the outcome increments once per read lookup in LOOKUP; writes are not counted.
  - Counters saturate at 0xFFFFFFFF.
  - Cleared by rst and by an accepted flush.
- CACHE_PERF_CNT_EN undefined: ports and logic are absent; all other behaviour is identical.

## Test plan
- Defaults. Reset, then read 0x1234: mem_req addr 0x1234, we = 0; memory returns 0xBEEF; resp_valid, hit = 0, rdata 0xBEEF. Read 0x1234 again: resp_valid 2 cycles after accept, hit = 1, rdata 0xBEEF, no mem_req.
- Read 0x1234, then 0x5634, then 0x1234: index 0x34 now holds both lines. Read 0x9A34: miss, evicts 0x5634. Then 0x1234 hits and 0x5634 misses.
- With 0x1234 cached, write 0x1234 = 0xCAFE: mem write addr 0x1234, data 0xCAFE; a later read hits with 0xCAFE. Write 0x7734 (miss): mem write issued; a later read of 0x7734 misses.
- Hold mem_req_ready low for 5 cycles during MEM_RD: mem_req_valid/addr stable, req_ready = 0 throughout; completes normally on the ready.
- In IDLE, assert flush and req_valid together: req_ready = 0 that cycle, request not accepted. A following read of 0x1234 misses. With CACHE_PERF_CNT_EN, counters read 0 after flush.
- Assert rst while in MEM_WAIT: next cycle mem_req_valid = 0, resp_valid stays 0, req_ready = 1 after rst deasserts. Read 0x1234 misses. With CACHE_PERF_CNT_EN, counters read 0.
